// File: rtl/gpioemu_pkg.sv
// Shared constants and types for the gpioemu job sequencer.
// Register map of the multiply/popcount peripheral plus FSM and bus-phase encodings.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam logic [1:0] STAT_DONE = 2'b11;

    localparam int OP_DW = 48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A1,
        S_WR_A2,
        S_WR_GO,
        S_POLL,
        S_RD_W,
        S_RD_L,
        S_EMIT
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } bus_phase_t;

endpackage

// File: rtl/gpioemu_job_seq_if.sv
// Operand stream, result stream and peripheral register bus of the job sequencer.
// slave = sequencer side, master = feeder/consumer/peripheral side.
interface gpioemu_job_seq_if;

    logic        op_valid;
    logic        op_ready;
    logic [23:0] op_a1;
    logic [23:0] op_a2;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_w;
    logic [5:0]  res_l;
    logic        res_err;

    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    modport slave (
        input  op_valid, op_a1, op_a2, res_ready, sdata_in,
        output op_ready, res_valid, res_w, res_l, res_err,
        output saddress, swr, srd, sdata_out
    );

    modport master (
        output op_valid, op_a1, op_a2, res_ready, sdata_in,
        input  op_ready, res_valid, res_w, res_l, res_err,
        input  saddress, swr, srd, sdata_out
    );

endinterface

// File: rtl/gpioemu_seq_fifo.sv
// Operand-pair FIFO: DEPTH entries (power of two), synchronous flush on reset.
// No bypass: a push is refused while full even if a pop happens in the same cycle.
module gpioemu_seq_fifo
    import gpioemu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [OP_DW-1:0] i_data,
    input  logic             i_pop,
    output logic [OP_DW-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [OP_DW-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_empty = (r_wp == r_rp);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/gpioemu_job_seq.sv
// Sequencer: buffers operand pairs and runs each job over the peripheral register bus.
// Define GPIOEMU_SEQ_TIMEOUT_EN to give up after POLL_LIMIT failed status polls.
module gpioemu_job_seq
    import gpioemu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int POLL_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    gpioemu_job_seq_if.slave s_if,
    output logic             busy,
    output logic [15:0]      job_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POLL_LIMIT < 1) begin : g_bad_cfg
        $error("gpioemu_job_seq: DEPTH must be a power of two >= 2, POLL_LIMIT >= 1");
    end

    seq_state_t  r_state;
    bus_phase_t  r_ph;
    logic [23:0] r_a2;
    logic [15:0] r_saddr;
    logic [31:0] r_sdo;
    logic        r_swr;
    logic        r_srd;
    logic        r_rv;
    logic [31:0] r_w;
    logic [5:0]  r_l;
    logic [15:0] r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [OP_DW-1:0] w_head;
    logic             w_wr;
    logic             w_done;

`ifdef GPIOEMU_SEQ_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] r_poll;
    logic           r_err;
    assign s_if.res_err = r_err;
`else
    assign s_if.res_err = 1'b0;
`endif

    assign w_pop  = (r_state == S_IDLE) && !w_empty;
    assign w_wr   = (r_state == S_WR_A1) || (r_state == S_WR_A2) ||
                    (r_state == S_WR_GO);
    assign w_done = (s_if.sdata_in[1:0] == STAT_DONE);

    gpioemu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (s_if.op_valid),
        .i_data  ({s_if.op_a1, s_if.op_a2}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Entering a bus state drives its SETUP; the end of HOLD samples and moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ph    <= PH_SETUP;
            r_a2    <= '0;
            r_saddr <= '0;
            r_sdo   <= '0;
            r_swr   <= 1'b0;
            r_srd   <= 1'b0;
            r_rv    <= 1'b0;
            r_w     <= '0;
            r_l     <= '0;
            r_cnt   <= '0;
`ifdef GPIOEMU_SEQ_TIMEOUT_EN
            r_poll  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_WR_A1;
                        r_ph    <= PH_SETUP;
                        r_a2    <= w_head[23:0];
                        r_saddr <= ADDR_A1;
                        r_sdo   <= {8'd0, w_head[47:24]};
                    end
                end
                S_EMIT: begin
                    if (s_if.res_ready) begin
                        r_rv    <= 1'b0;
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    case (r_ph)
                        PH_SETUP: begin
                            r_swr <= w_wr;
                            r_srd <= !w_wr;
                            r_ph  <= PH_STROBE;
                        end
                        PH_STROBE: begin
                            r_swr <= 1'b0;
                            r_srd <= 1'b0;
                            r_ph  <= PH_HOLD;
                        end
                        default: begin
                            r_ph <= PH_SETUP;
                            case (r_state)
                                S_WR_A1: begin
                                    r_state <= S_WR_A2;
                                    r_saddr <= ADDR_A2;
                                    r_sdo   <= {8'd0, r_a2};
                                end
                                S_WR_A2: begin
                                    r_state <= S_WR_GO;
                                    r_saddr <= ADDR_CTRL;
                                    r_sdo   <= 32'd1;
                                end
                                S_WR_GO: begin
                                    r_state <= S_POLL;
                                    r_saddr <= ADDR_CTRL;
                                    r_sdo   <= '0;
`ifdef GPIOEMU_SEQ_TIMEOUT_EN
                                    r_poll  <= '0;
`endif
                                end
                                S_POLL: begin
                                    if (w_done) begin
                                        r_state <= S_RD_W;
                                        r_saddr <= ADDR_W;
                                    end
`ifdef GPIOEMU_SEQ_TIMEOUT_EN
                                    else if (r_poll == PCW'(POLL_LIMIT - 1)) begin
                                        r_state <= S_EMIT;
                                        r_rv    <= 1'b1;
                                        r_w     <= '0;
                                        r_l     <= '0;
                                        r_err   <= 1'b1;
                                    end else begin
                                        r_poll <= r_poll + 1'b1;
                                    end
`endif
                                end
                                S_RD_W: begin
                                    r_w     <= s_if.sdata_in;
                                    r_state <= S_RD_L;
                                    r_saddr <= ADDR_L;
                                end
                                S_RD_L: begin
                                    r_l     <= s_if.sdata_in[5:0];
                                    r_rv    <= 1'b1;
                                    r_state <= S_EMIT;
`ifdef GPIOEMU_SEQ_TIMEOUT_EN
                                    r_err   <= 1'b0;
`endif
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign s_if.op_ready  = !w_full;
    assign s_if.res_valid = r_rv;
    assign s_if.res_w     = r_w;
    assign s_if.res_l     = r_l;
    assign s_if.saddress  = r_saddr;
    assign s_if.swr       = r_swr;
    assign s_if.srd       = r_srd;
    assign s_if.sdata_out = r_sdo;
    assign busy           = (r_state != S_IDLE);
    assign job_count      = r_cnt;

endmodule

// File: tb/tb_gpioemu_job_seq.sv
// Bench for gpioemu_job_seq: random jobs against a peripheral model and result scoreboard.
// Timeout scenario runs only when GPIOEMU_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_gpioemu_job_seq;
    import gpioemu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] job_count;

    gpioemu_job_seq_if u_if ();

    gpioemu_job_seq #(.DEPTH(4), .POLL_LIMIT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_if      (u_if),
        .busy      (busy),
        .job_count (job_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  l;
        logic        e;
    } res_t;

    res_t        expq[$];
    logic [15:0] addr_log[$];
    int          cyc = 0;
    int          exp_jobs = 0;
    int          push_cyc = 0;
    int          rv_rise_cyc = 0;
    int          stb_cnt = 0;
    int          polls = 0;
    int          done_after = 1;
    int          rr_mode = 1;
    bit          rnd_done = 0;
    bit          tmo_mode = 0;
    bit          hs_pend = 0;
    logic        prev_stb = 1'b0;
    logic        prev_rv = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] stb_addr = '0;
    logic [23:0] pa1 = '0;
    logic [23:0] pa2 = '0;

    always @(posedge clk) cyc++;

    function automatic res_t model(input logic [23:0] a1, input logic [23:0] a2);
        res_t r;
        logic [47:0] p;
        p   = 48'(a1) * 48'(a2);
        r.w = p[31:0];
        r.l = 6'($countones(p[31:0]));
        r.e = 1'b0;
        return r;
    endfunction

    // Peripheral model, bus-timing monitor and result scoreboard.
    always @(negedge clk) begin
        case (rr_mode)
            0: u_if.res_ready = 1'b0;
            1: u_if.res_ready = 1'b1;
            default: u_if.res_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset) begin
            expq.delete();
            exp_jobs = 0;
            hs_pend = 0;
            prev_stb = 1'b0;
            prev_rv = 1'b0;
            u_if.sdata_in = '0;
        end else begin
            if (hs_pend) begin
                chk("job_count", 32'(job_count), 32'(exp_jobs));
                hs_pend = 0;
            end
            if (prev_stb) chk("addr_hold", 32'(u_if.saddress), 32'(stb_addr));
            if (u_if.swr || u_if.srd) begin
                chk("both_stb", 32'(u_if.swr & u_if.srd), 0);
                chk("stb_len", 32'(prev_stb), 0);
                chk("addr_setup", 32'(u_if.saddress), 32'(prev_addr));
                chk("emit_quiet", 32'(u_if.res_valid), 0);
                stb_cnt++;
                stb_addr = u_if.saddress;
                addr_log.push_back(u_if.saddress);
                if (u_if.swr) begin
                    if (u_if.saddress == ADDR_A1 || u_if.saddress == ADDR_A2)
                        chk("wr_zext", 32'(u_if.sdata_out[31:24]), 0);
                    if (u_if.saddress == ADDR_A1) pa1 = u_if.sdata_out[23:0];
                    if (u_if.saddress == ADDR_A2) pa2 = u_if.sdata_out[23:0];
                    if (u_if.saddress == ADDR_CTRL && u_if.sdata_out[0]) begin
                        polls = 0;
                        if (rnd_done) done_after = $urandom_range(1, 3);
                    end
                end else begin
                    case (u_if.saddress)
                        ADDR_CTRL: begin
                            polls++;
                            u_if.sdata_in = (done_after != 0 && polls >= done_after)
                                            ? 32'h3 : 32'h1;
                        end
                        ADDR_W: u_if.sdata_in = model(pa1, pa2).w;
                        ADDR_L: u_if.sdata_in = 32'(model(pa1, pa2).l);
                        default: u_if.sdata_in = 32'hDEAD_BEEF;
                    endcase
                end
            end
            prev_stb = u_if.swr | u_if.srd;
            prev_addr = u_if.saddress;
            if (u_if.res_valid && !prev_rv) rv_rise_cyc = cyc;
            prev_rv = u_if.res_valid;
            if (u_if.res_valid && u_if.res_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_res", 1, 0);
                end else begin
                    res_t e;
                    e = expq.pop_front();
                    chk("res_w", u_if.res_w, e.w);
                    chk("res_l", 32'(u_if.res_l), 32'(e.l));
                    chk("res_err", 32'(u_if.res_err), 32'(e.e));
                end
                exp_jobs = (exp_jobs + 1) & 16'hFFFF;
                hs_pend = 1;
            end
        end
    end

    task automatic push(input logic [23:0] a1, input logic [23:0] a2,
                        input int budget, output bit ok);
        int n = 0;
        res_t e;
        ok = 0;
        @(negedge clk);
        u_if.op_valid = 1'b1;
        u_if.op_a1 = a1;
        u_if.op_a2 = a2;
        while (!u_if.op_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (u_if.op_ready) begin
            ok = 1;
            push_cyc = cyc + 1;
            e = tmo_mode ? res_t'{w: 32'd0, l: 6'd0, e: 1'b1} : model(a1, a2);
            expq.push_back(e);
            @(negedge clk);
        end
        u_if.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(expq.size() == 0 && !busy), 1);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_op_ready"}, 32'(u_if.op_ready), 1);
        chk({t, "_res_valid"}, 32'(u_if.res_valid), 0);
        chk({t, "_res_w"}, u_if.res_w, 0);
        chk({t, "_res_l"}, 32'(u_if.res_l), 0);
        chk({t, "_res_err"}, 32'(u_if.res_err), 0);
        chk({t, "_saddress"}, 32'(u_if.saddress), 0);
        chk({t, "_swr"}, 32'(u_if.swr), 0);
        chk({t, "_srd"}, 32'(u_if.srd), 0);
        chk({t, "_sdata_out"}, u_if.sdata_out, 0);
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_job_count"}, 32'(job_count), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc;
        int n;
        bit seen;
        logic [15:0] exp_seq[7];
        exp_seq = '{16'h0380, 16'h0388, 16'h03A0, 16'h03A0,
                    16'h03A0, 16'h0390, 16'h0398};
        u_if.op_valid = 1'b0;
        u_if.op_a1 = '0;
        u_if.op_a2 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;

        // Basic job, status done on the second poll
        done_after = 2;
        addr_log.delete();
        push(24'd3, 24'd5, 20, ok);
        chk("t1_push", 32'(ok), 1);
        wait_idle("t1_idle", 200);
        chk("t1_nacc", 32'(addr_log.size()), 7);
        for (int i = 0; i < 7; i++)
            if (i < addr_log.size()) chk($sformatf("t1_addr%0d", i), 32'(addr_log[i]), 32'(exp_seq[i]));
        chk("t1_lat", 32'(rv_rise_cyc - push_cyc), 22);
        chk("t1_w", u_if.res_w, 32'd15);
        chk("t1_l", 32'(u_if.res_l), 4);
        chk("t1_jobs", 32'(job_count), 1);

        // First-poll latency
        done_after = 1;
        push(24'($urandom), 24'($urandom), 20, ok);
        wait_idle("lat_idle", 200);
        chk("lat19", 32'(rv_rise_cyc - push_cyc), 19);

        // Maximum operands
        push(24'hFFFFFF, 24'hFFFFFF, 20, ok);
        wait_idle("t2_idle", 200);
        chk("t2_w", u_if.res_w, 32'hFE000001);
        chk("t2_l", 32'(u_if.res_l), 8);

        // Back-pressure: one job in flight plus a full FIFO
        rr_mode = 0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(24'($urandom), 24'($urandom), 30, ok);
            acc += int'(ok);
        end
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_op_ready", 32'(u_if.op_ready), 0);
        n = 0;
        while (!u_if.res_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_emit", 32'(u_if.res_valid), 1);
        acc = stb_cnt;
        repeat (20) @(negedge clk);
        chk("bp_quiet", 32'(stb_cnt - acc), 0);
        chk("bp_busy", 32'(busy), 1);
        rr_mode = 1;
        push(24'($urandom), 24'($urandom), 100, ok);
        chk("bp_push6", 32'(ok), 1);
        wait_idle("bp_drain", 800);

        // Random operands, poll counts and consumer stalls
        rnd_done = 1;
        rr_mode = 2;
        for (int i = 0; i < 8; i++) begin
            push(24'($urandom), 24'($urandom), 200, ok);
            chk("rnd_push", 32'(ok), 1);
        end
        wait_idle("rnd_drain", 2000);
        rnd_done = 0;
        rr_mode = 1;

        // Reset while polling, with more jobs queued
        done_after = 0;
        push(24'($urandom), 24'($urandom), 20, ok);
        push(24'($urandom), 24'($urandom), 20, ok);
        push(24'($urandom), 24'($urandom), 20, ok);
        n = 0;
        while (polls < 3 && n < 300) begin @(negedge clk); n++; end
        chk("mid_polling", 32'(polls >= 3), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("mid_rst");
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || u_if.swr || u_if.srd || u_if.res_valid) seen = 1;
        end
        chk("mid_flushed", 32'(seen), 0);
        done_after = 1;
        push(24'h000123, 24'h000456, 20, ok);
        wait_idle("mid_fresh", 200);
        chk("mid_w", u_if.res_w, 32'h0004_EDC2);
        chk("mid_jobs", 32'(job_count), 1);

`ifdef GPIOEMU_SEQ_TIMEOUT_EN
        // Status never completes: give up after 255 failed polls
        done_after = 0;
        tmo_mode = 1;
        addr_log.delete();
        push(24'($urandom), 24'($urandom), 20, ok);
        n = 0;
        while (!u_if.res_valid && n < 1200) begin @(negedge clk); n++; end
        chk("tmo_rv", 32'(u_if.res_valid), 1);
        chk("tmo_polls", 32'(polls), 255);
        chk("tmo_err", 32'(u_if.res_err), 1);
        chk("tmo_w", u_if.res_w, 0);
        acc = 0;
        n = 0;
        foreach (addr_log[i]) begin
            if (addr_log[i] == ADDR_W || addr_log[i] == ADDR_L) acc++;
            if (addr_log[i] == ADDR_CTRL) n++;
        end
        chk("tmo_no_rd", 32'(acc), 0);
        chk("tmo_ctrl", 32'(n), 256);
        wait_idle("tmo_idle", 100);
        chk("tmo_jobs", 32'(job_count), 2);
        tmo_mode = 0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
